// File: rtl/hdb3_pat_sched_if.sv
// Handshake and data bundle between a test sequencer and hdb3_pat_sched.
//   master : sequencer side, drives start/stop and the run parameters,
//            observes the emitted bit stream and status.
//   slave  : scheduler side, the mirror image of master.
// Signals:
//   i_start, i_stop       start request / abort request
//   i_pattern, i_pat_len  test pattern (MSB first) and number of bits used
//   i_bit_count, i_div    bits to emit (0 = continuous), bit period - 1
//   o_bit, o_bit_valid    current bit and its one-cycle strobe
//   o_busy, o_done        run in progress / natural completion pulse
//   o_bits_sent           bits emitted since the last accepted start
interface hdb3_pat_sched_if #(
    parameter int unsigned PAT_W = 32,
    parameter int unsigned LEN_W = 6,
    parameter int unsigned CNT_W = 16,
    parameter int unsigned DIV_W = 8
);
    logic             i_start;
    logic             i_stop;
    logic [PAT_W-1:0] i_pattern;
    logic [LEN_W-1:0] i_pat_len;
    logic [CNT_W-1:0] i_bit_count;
    logic [DIV_W-1:0] i_div;
    logic             o_bit;
    logic             o_bit_valid;
    logic             o_busy;
    logic             o_done;
    logic [CNT_W-1:0] o_bits_sent;

    modport master (
        output i_start, i_stop, i_pattern, i_pat_len, i_bit_count, i_div,
        input  o_bit, o_bit_valid, o_busy, o_done, o_bits_sent
    );

    modport slave (
        input  i_start, i_stop, i_pattern, i_pat_len, i_bit_count, i_div,
        output o_bit, o_bit_valid, o_busy, o_done, o_bits_sent
    );
endinterface

// File: rtl/hdb3_pat_sched.sv
// Bit-stream scheduler feeding the HDB3 encoder test path.
// A programmable pattern is latched on an accepted start and emitted MSB
// first, one bit per strobe, every i_div+1 clocks. The run ends after
// i_bit_count bits (o_done pulse) or continues until i_stop when the count
// is zero. All outputs are registered.
// Ports:
//   i_clk    clock, rising edge
//   i_rst_n  synchronous active-low reset
//   bus      hdb3_pat_sched_if slave modport (start/stop, run parameters,
//            bit stream and status outputs)
module hdb3_pat_sched #(
    parameter int unsigned PAT_W = 32,
    parameter int unsigned LEN_W = 6,
    parameter int unsigned CNT_W = 16,
    parameter int unsigned DIV_W = 8
) (
    input logic              i_clk,
    input logic              i_rst_n,
    hdb3_pat_sched_if.slave  bus
);

    localparam int unsigned      PTR_W  = (PAT_W > 1) ? $clog2(PAT_W) : 1;
    localparam logic [LEN_W-1:0] PatLen = LEN_W'(PAT_W);
    localparam logic [PTR_W-1:0] PtrTop = PTR_W'(PAT_W - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state_q;
    logic [PAT_W-1:0] pat_q;
    logic [PTR_W-1:0] ptr_q;
    // Pointer value of the last used pattern bit (PAT_W - L); stored instead
    // of L so the wrap test is a plain equality.
    logic [PTR_W-1:0] wrap_q;
    // Bits still to emit in count mode; stays 0 in continuous mode.
    logic [CNT_W-1:0] remain_q;
    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] divcnt_q;
    logic [CNT_W-1:0] sent_q;
    logic             bit_q;
    logic             valid_q;
    logic             busy_q;
    logic             done_q;

    logic [LEN_W-1:0] eff_len;
    logic [PTR_W-1:0] wrap_start;

    // Length 0 or anything beyond the register width selects the full pattern.
    always_comb begin
        eff_len = bus.i_pat_len;
        if (bus.i_pat_len == '0 || bus.i_pat_len > PatLen) begin
            eff_len = PatLen;
        end
        wrap_start = PTR_W'(PatLen - eff_len);
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q  <= StIdle;
            pat_q    <= '0;
            ptr_q    <= '0;
            wrap_q   <= '0;
            remain_q <= '0;
            div_q    <= '0;
            divcnt_q <= '0;
            sent_q   <= '0;
            bit_q    <= 1'b0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (bus.i_start && !bus.i_stop) begin
                        pat_q    <= bus.i_pattern;
                        wrap_q   <= wrap_start;
                        remain_q <= bus.i_bit_count;
                        div_q    <= bus.i_div;
                        ptr_q    <= PtrTop;
                        divcnt_q <= '0;
                        sent_q   <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= StRun;
                    end
                end
                StRun: begin
                    if (bus.i_stop) begin
                        busy_q  <= 1'b0;
                        state_q <= StIdle;
                    end else if (divcnt_q == '0) begin
                        bit_q    <= pat_q[ptr_q];
                        valid_q  <= 1'b1;
                        sent_q   <= sent_q + 1'b1;
                        divcnt_q <= div_q;
                        ptr_q    <= (ptr_q == wrap_q) ? PtrTop : ptr_q - 1'b1;
                        if (remain_q == CNT_W'(1)) begin
                            state_q <= StDone;
                        end else if (remain_q != '0) begin
                            remain_q <= remain_q - 1'b1;
                        end
                    end else begin
                        divcnt_q <= divcnt_q - 1'b1;
                    end
                end
                StDone: begin
                    // An abort landing on the completion edge swallows the pulse.
                    done_q  <= !bus.i_stop;
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign bus.o_bit       = bit_q;
    assign bus.o_bit_valid = valid_q;
    assign bus.o_busy      = busy_q;
    assign bus.o_done      = done_q;
    assign bus.o_bits_sent = sent_q;

endmodule

// File: tb/tb_hdb3_pat_sched.sv
// Scoreboard bench for hdb3_pat_sched. The stimulus process predicts every
// strobe (bit, running count, clock edge) and every done pulse from the
// pattern rules and pushes them into queues; the monitor pops and compares
// whenever the DUT strobes.
module tb_hdb3_pat_sched;

    logic i_clk = 1'b0;
    logic i_rst_n = 1'b0;
    int   cyc = 0;
    int   n_pass = 0;
    int   n_total = 0;
    logic last_bit = 1'b0;

    typedef struct {
        logic        b;
        logic [15:0] sent;
        int          at;
    } strobe_t;

    typedef struct {
        logic [15:0] sent;
        int          at;
    } done_t;

    strobe_t exp_q[$];
    done_t   done_q[$];

    hdb3_pat_sched_if #(.PAT_W(32), .LEN_W(6), .CNT_W(16), .DIV_W(8)) bus ();

    hdb3_pat_sched #(.PAT_W(32), .LEN_W(6), .CNT_W(16), .DIV_W(8)) dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .bus     (bus)
    );

    always #5 i_clk = ~i_clk;

    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Monitor: outputs are sampled on the falling edge, half a period after
    // the edge that produced them, so cyc names that edge.
    always @(negedge i_clk) begin
        if (bus.o_bit_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL strobe: unexpected strobe at cycle %0d", cyc);
            end else begin
                strobe_t s;
                s = exp_q.pop_front();
                chk("strobe", {bus.o_bit, bus.o_bits_sent, 32'(cyc)}, {s.b, s.sent, 32'(s.at)});
            end
        end
        if (bus.o_done === 1'b1) begin
            if (done_q.size() == 0) begin
                n_total++;
                $display("FAIL done: unexpected done pulse at cycle %0d", cyc);
            end else begin
                done_t d;
                d = done_q.pop_front();
                chk("done", {bus.o_busy, bus.o_bits_sent, 32'(cyc)}, {1'b0, d.sent, 32'(d.at)});
            end
        end
    end

    task automatic scramble_inputs();
        bus.i_pattern   = $urandom;
        bus.i_pat_len   = 6'($urandom_range(0, 40));
        bus.i_bit_count = 16'($urandom_range(0, 20));
        bus.i_div       = 8'($urandom_range(0, 5));
    endtask

    // kind: 0 = run to completion, 1 = i_stop at edge abort_rel, 2 = reset at
    // edge abort_rel (edges counted from the accepting edge, which is 0).
    task automatic run(input logic [31:0] pat, input logic [5:0] len, input logic [15:0] cnt,
                       input logic [7:0] div, input int kind_in, input int abort_rel,
                       input bit noise);
        int eff_l, per, c0, end_rel, n_emit, kind;
        bit exp_done;
        kind = kind_in;
        eff_l = (len == 6'd0 || len > 6'd32) ? 32 : int'(len);
        per = int'(div) + 1;
        exp_done = 1'b0;
        end_rel = abort_rel;
        if (cnt != 16'd0) begin
            end_rel = 2 + (int'(cnt) - 1) * per;
            exp_done = 1'b1;
            if (kind != 0 && abort_rel <= end_rel) begin
                end_rel = abort_rel;
                exp_done = 1'b0;
            end else begin
                kind = 0;
            end
        end
        n_emit = 0;
        while (1 + n_emit * per < end_rel && (cnt == 16'd0 || n_emit < int'(cnt))) n_emit++;

        @(negedge i_clk);
        bus.i_pattern   = pat;
        bus.i_pat_len   = len;
        bus.i_bit_count = cnt;
        bus.i_div       = div;
        bus.i_start     = 1'b1;
        bus.i_stop      = 1'b0;
        c0 = cyc + 1;
        for (int k = 0; k < n_emit; k++) begin
            strobe_t s;
            s.b    = pat[31 - (k % eff_l)];
            s.sent = 16'(k + 1);
            s.at   = c0 + 1 + k * per;
            exp_q.push_back(s);
        end
        if (exp_done) begin
            done_t d;
            d.sent = cnt;
            d.at   = c0 + end_rel;
            done_q.push_back(d);
        end
        if (n_emit > 0) last_bit = pat[31 - ((n_emit - 1) % eff_l)];

        @(negedge i_clk);
        bus.i_start = 1'b0;
        chk("busy_after_start", {63'd0, bus.o_busy}, 64'd1);
        while (cyc < c0 + end_rel - 1) begin
            if (noise) begin
                bus.i_start = 1'($urandom_range(0, 1));
                scramble_inputs();
            end
            @(negedge i_clk);
        end
        bus.i_start = 1'b0;
        if (kind == 1) bus.i_stop = 1'b1;
        if (kind == 2) i_rst_n = 1'b0;
        @(negedge i_clk);
        bus.i_stop = 1'b0;

        if (kind == 2) begin
            last_bit = 1'b0;
            chk("reset_outputs", {44'd0, bus.o_bit, bus.o_bit_valid, bus.o_busy, bus.o_done,
                                  bus.o_bits_sent}, 64'd0);
            @(negedge i_clk);
            chk("reset_held", {44'd0, bus.o_bit, bus.o_bit_valid, bus.o_busy, bus.o_done,
                               bus.o_bits_sent}, 64'd0);
            i_rst_n = 1'b1;
            repeat (3) @(negedge i_clk);
            chk("post_reset_idle", {47'd0, bus.o_busy, bus.o_bits_sent}, 64'd0);
        end else begin
            chk("end_busy_valid", {62'd0, bus.o_busy, bus.o_bit_valid}, 64'd0);
            chk("end_sent", {48'd0, bus.o_bits_sent}, {48'd0, 16'(n_emit)});
            chk("hold_bit", {63'd0, bus.o_bit}, {63'd0, last_bit});
        end
    endtask

    initial begin
        bus.i_start     = 1'b0;
        bus.i_stop      = 1'b0;
        bus.i_pattern   = '0;
        bus.i_pat_len   = '0;
        bus.i_bit_count = '0;
        bus.i_div       = '0;

        repeat (2) @(negedge i_clk);
        chk("reset_state", {44'd0, bus.o_bit, bus.o_bit_valid, bus.o_busy, bus.o_done,
                            bus.o_bits_sent}, 64'd0);
        i_rst_n = 1'b1;
        repeat (2) @(negedge i_clk);
        chk("idle_after_reset", {47'd0, bus.o_busy, bus.o_bits_sent}, 64'd0);

        // Full-width pattern, eight bits back to back.
        run(32'h8900_F080, 6'd0, 16'd8, 8'd0, 0, 0, 1'b0);
        // Four-bit pattern repeating, one bit every three clocks.
        run(32'hA000_0000, 6'd4, 16'd10, 8'd2, 0, 0, 1'b0);
        // Continuous, aborted on the edge after the 40th emission.
        run(32'h8900_F080, 6'd32, 16'd0, 8'd0, 1, 41, 1'b0);
        // Start pulses and input churn while running must not disturb the run.
        run(32'hC3A5_0F1E, 6'd12, 16'd15, 8'd1, 0, 0, 1'b1);

        // Start and stop together in IDLE: nothing starts.
        @(negedge i_clk);
        bus.i_start = 1'b1;
        bus.i_stop  = 1'b1;
        @(negedge i_clk);
        bus.i_start = 1'b0;
        bus.i_stop  = 1'b0;
        chk("start_stop_idle", {63'd0, bus.o_busy}, 64'd0);
        repeat (4) @(negedge i_clk);
        chk("start_stop_idle_later", {63'd0, bus.o_busy}, 64'd0);

        // Stop on the DONE edge suppresses the pulse (last emission at edge 5).
        run(32'h6000_0000, 6'd0, 16'd3, 8'd1, 1, 6, 1'b0);
        // Single-bit pattern.
        run(32'h8000_0000, 6'd1, 16'd3, 8'd0, 0, 0, 1'b0);
        // Reset mid-run.
        run(32'hF0F0_1234, 6'd20, 16'd30, 8'd1, 2, 17, 1'b0);
        // Back-to-back starts after a reset.
        run(32'h1234_5678, 6'd33, 16'd5, 8'd0, 0, 0, 1'b0);

        for (int i = 0; i < 20; i++) begin
            logic [31:0] p;
            logic [5:0]  l;
            logic [15:0] c;
            logic [7:0]  d;
            int          k;
            int          ar;
            p = $urandom;
            l = 6'($urandom_range(0, 40));
            c = 16'($urandom_range(0, 20));
            d = 8'($urandom_range(0, 3));
            if (c == 16'd0) begin
                k  = 1;
                ar = $urandom_range(1, 60);
            end else begin
                k  = ($urandom_range(0, 3) == 0) ? 1 : 0;
                ar = $urandom_range(1, 2 + (int'(c) - 1) * (int'(d) + 1));
            end
            run(p, l, c, d, k, ar, 1'($urandom_range(0, 1)));
        end

        // Largest count: done after exactly 65535 strobes.
        run(32'hDEAD_BEEF, 6'd0, 16'hFFFF, 8'd0, 0, 0, 1'b0);

        repeat (3) @(negedge i_clk);
        chk("queues_drained", 64'(exp_q.size() + done_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/hdb3_pat_sched.md
# hdb3_pat_sched

Bit-stream scheduler for the HDB3 test path. It loads a programmable test pattern and emits it one bit per strobe into the HDB3 encoder. Emission runs at a programmable bit rate, for a programmed number of bits or continuously. It also provides a start/stop/done handshake so a test sequencer can run repeated stimulus bursts without reprogramming a fixed ROM pattern.

## Interface
- PAT_W, 32, pattern register width (bits)
- LEN_W, 6, width of pattern-length input; must hold PAT_W
- CNT_W, 16, width of bit-count and sent-counter
- DIV_W, 8, width of bit-rate divider
- i_clk  in  1  clock; all logic on rising edge
- i_rst_n  in  1  reset, synchronous, active-low
- i_start  in  1  start request; accepted only in IDLE
- i_stop  in  1  abort request; any state
- i_pattern  in  PAT_W  pattern; MSB emitted first
- i_pat_len  in  LEN_W  number of pattern bits used, L; 0 or >PAT_W means PAT_W
- i_bit_count  in  CNT_W  bits to emit; 0 = continuous
- i_div  in  DIV_W  bit period = i_div+1 clocks
- o_bit  out  1  current bit; holds value between strobes
- o_bit_valid  out  1  one-cycle strobe per emitted bit
- o_busy  out  1  high in RUN and DONE
- o_done  out  1  one-cycle pulse on natural completion
- o_bits_sent  out  CNT_W  bits emitted since last accepted start; wraps mod 2^CNT_W

## Operation
- States: IDLE, RUN, DONE. All outputs registered.
- Reset (i_rst_n=0 at an edge): state IDLE; all outputs 0; internal pattern, pointer, remaining and divider registers 0. With no edge, nothing changes.
- IDLE:
  - i_start=1 and i_stop=0 at an edge:
    - latch i_pattern, effective L, i_bit_count, i_div;
    - set pointer to PAT_W-1, divider counter to 0, o_bits_sent to 0, o_busy to 1;
    - go to RUN.
  - Otherwise stay in IDLE.
- RUN, every edge, in priority order:
  1. i_stop=1: go to IDLE; o_busy=0, o_bit_valid=0, no o_done.
  2. Divider counter==0 (emission edge):
     - o_bit = pattern[pointer], o_bit_valid=1, o_bits_sent+1;
     - divider reloads to latched div;
     - pointer: if pointer==PAT_W-L, wrap to PAT_W-1; else decrement;
     - if count mode and remaining==1, go to DONE; else decrement remaining (count mode only).
  3. Otherwise: o_bit_valid=0, divider decrements.
- DONE, next edge:
  - o_done=1 for that one cycle, o_bit_valid=0, o_busy=0; go to IDLE.
  - i_stop=1 on this edge suppresses o_done.
- Continuous mode (count 0): pattern repeats every L bits until i_stop.
- i_start outside IDLE is ignored; there is no queueing.
- o_bit keeps its last value after completion or abort until the next emission; it is cleared only by reset.
- Inputs are sampled only at start acceptance. Later changes to inputs have no effect on the run in progress.

## Timing
- Start accepted at edge E0. First emission at E1; o_bit_valid is high during the cycle after E1.
- Subsequent emissions occur at E1 + k·(i_div+1).
- Count N: last emission at E1 + (N-1)(i_div+1). The o_done pulse and the o_busy fall are registered on the following edge. A new start is accepted from the edge after that.
- Stop at edge Es: o_busy and o_bit_valid are 0 after Es; no further emission.
- Same-edge precedence: reset > stop > emission/start.

## Test plan
- Reset: hold i_rst_n=0 for 2 edges mid-run -> all outputs 0 after the first low edge. Deassert with no start -> stays IDLE, o_bits_sent=0.
- Start with pattern=32'h8900_F080, pat_len=0, count=8, div=0 -> o_bit_valid high on 8 consecutive cycles with bits 1,0,0,0,1,0,0,1. o_done is one cycle after the last strobe, o_bits_sent=8, o_busy low with o_done.
- Start with pattern=32'hA000_0000, pat_len=4, count=10, div=2 -> strobes every 3 cycles with bits 1,0,1,0,1,0,1,0,1,0. o_done once after the tenth strobe.
- Continuous run with pattern=32'h8900_F080, pat_len=32, count=0, div=0, stop after the 40th strobe -> bits 33..40 equal bits 1..8, o_bits_sent=40, no o_done, o_busy 0 the cycle after stop.
- Collisions:
  - i_start pulsed during RUN -> ignored; bit sequence and count unchanged.
  - i_start and i_stop together in IDLE -> stays IDLE, o_busy=0.
  - i_stop in DONE -> no o_done.
- Count wrap and boundaries:
  - count=16'hFFFF, div=0 -> o_done after exactly 65535 strobes, o_bits_sent=16'hFFFF.
  - pat_len=1, pattern MSB=1, count=3 -> bits 1,1,1.
